// File: rtl/alu_pipe_if.sv
// Handshake/data bundle for alu_pipe: producer side drives operands, consumer side drives out_ready.
interface alu_pipe_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [NB_DATA-1:0] dato_a;
  logic [NB_DATA-1:0] dato_b;
  logic [NB_OP-1:0]   op;
  logic               out_valid;
  logic               out_ready;
  logic [NB_DATA-1:0] res;
  logic [4:0]         flags;

  modport master (
    output in_valid, dato_a, dato_b, op, out_ready,
    input  in_ready, out_valid, res, flags
  );

  modport slave (
    input  in_valid, dato_a, dato_b, op, out_ready,
    output in_ready, out_valid, res, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers the operation, S2 registers result and
// flags {err, ovf, carry, neg, zero}.
module alu_pipe #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int          MSB   = NB_DATA - 1;
  localparam logic [31:0] WIDTH = NB_DATA;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(8'h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(8'h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(8'h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(8'h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(8'h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(8'h27);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(8'h02);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(8'h03);

  logic               s1_valid;
  logic [NB_DATA-1:0] s1_a;
  logic [NB_DATA-1:0] s1_b;
  logic [NB_OP-1:0]   s1_op;
  logic               s2_valid;
  logic [NB_DATA-1:0] s2_res;
  logic [4:0]         s2_flags;

  logic s1_en;
  logic s2_en;

  logic [NB_DATA:0]          sum;
  logic [NB_DATA:0]          diff;
  logic [31:0]               sh;
  logic signed [NB_DATA-1:0] sra_v;
  logic [NB_DATA-1:0]        alu_res;
  logic                      alu_err;
  logic                      alu_ovf;
  logic                      alu_carry;

  assign s2_en = !s2_valid || bus.out_ready;
  assign s1_en = !s1_valid || s2_en;

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_valid;
  assign bus.res       = s2_res;
  assign bus.flags     = s2_flags;

  always_comb begin
    alu_res   = '0;
    alu_err   = 1'b0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    sh        = 32'(s1_b);
    sum       = {1'b0, s1_a} + {1'b0, s1_b};
    // top bit of the widened difference is the unsigned borrow (A < B)
    diff      = {1'b0, s1_a} - {1'b0, s1_b};
    sra_v     = $signed(s1_a) >>> sh;
    case (s1_op)
      OP_ADD: begin
        alu_res   = sum[MSB:0];
        alu_carry = sum[NB_DATA];
        alu_ovf   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        alu_res   = diff[MSB:0];
        alu_carry = diff[NB_DATA];
        alu_ovf   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_NOR: alu_res = ~(s1_a | s1_b);
      OP_SRL: alu_res = (sh >= WIDTH) ? '0 : (s1_a >> sh);
      OP_SRA: alu_res = (sh >= WIDTH) ? {NB_DATA{s1_a[MSB]}} : sra_v;
      default: begin
        alu_err = 1'b1;
        for (int unsigned i = 0; i < NB_DATA; i++) alu_res[i] = (i % 2 == 1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a  <= bus.dato_a;
          s1_b  <= bus.dato_b;
          s1_op <= bus.op;
        end
      end
      // result registers load only with real data, so bubbles leave them untouched
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_res   <= alu_res;
          s2_flags <= {alu_err, alu_ovf, alu_carry, alu_res[MSB], alu_res == '0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, stall/reset sequences and
// random traffic against an arithmetic reference model with an in-order scoreboard.
module tb_alu_pipe;
  logic clk;
  logic rst_n;
  int   tests;
  int   errors;

  alu_pipe_if #(.NB_DATA(8), .NB_OP(8)) bus ();

  alu_pipe #(.NB_DATA(8), .NB_OP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] flags;
  } vec_t;

  logic [12:0] exp_q[$];
  logic        stall_prev;
  logic [7:0]  prev_res;
  logic [4:0]  prev_flags;
  logic [7:0]  got_res;
  logic [4:0]  got_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // returns {err, ovf, carry, neg, zero, res}
  function automatic logic [12:0] model(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r;
    logic [7:0] res;
    logic err, ovf, carry;
    err = 1'b0; ovf = 1'b0; carry = 1'b0; res = 8'h00;
    case (o)
      8'h20: begin r = ua + ub; res = 8'(r % 256); carry = (r > 255);
                   ovf = (sa + sb > 127) || (sa + sb < -128); end
      8'h22: begin r = ua - ub; res = 8'((r + 256) % 256); carry = (ua < ub);
                   ovf = (sa - sb > 127) || (sa - sb < -128); end
      8'h24: res = a & b;
      8'h25: res = a | b;
      8'h26: res = a ^ b;
      8'h27: res = ~(a | b);
      8'h02: res = (ub >= 8) ? 8'h00 : 8'(ua / (1 << ub));
      8'h03: res = (ub >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> ub);
      default: begin res = 8'hAA; err = 1'b1; end
    endcase
    return {err, ovf, carry, res[7], res == 8'h00, res};
  endfunction

  // one cycle: drive at negedge, sample #1 later, score the transfers happening at the next posedge
  task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                      input logic ordy, output logic in_fire, output logic out_fire);
    int n;
    logic [12:0] e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.dato_a    = a;
    bus.dato_b    = b;
    bus.op        = o;
    bus.out_ready = ordy;
    #1;
    n = exp_q.size();
    check("in_ready_vs_occupancy", 32'(bus.in_ready), 32'((n < 2) || ordy));
    if (n == 0) check("out_valid_when_empty", 32'(bus.out_valid), 32'd0);
    if (stall_prev) begin
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_res_stable", 32'(bus.res), 32'(prev_res));
      check("stall_flags_stable", 32'(bus.flags), 32'(prev_flags));
    end
    in_fire  = iv && bus.in_ready;
    out_fire = bus.out_valid && ordy;
    if (out_fire) begin
      got_res   = bus.res;
      got_flags = bus.flags;
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_res", 32'(bus.res), 32'(e[7:0]));
        check("sb_flags", 32'(bus.flags), 32'(e[12:8]));
      end
    end
    if (in_fire) exp_q.push_back(model(o, a, b));
    stall_prev = bus.out_valid && !ordy;
    prev_res   = bus.res;
    prev_flags = bus.flags;
  endtask

  task automatic drain(input string name);
    logic fi, fo;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, fi, fo);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[14];
  logic [7:0] ops[9];

  initial begin
    logic fi, fo;
    int   lat, k, outs;
    logic saw_drop, got;
    logic [7:0] a, b, o;

    tests = 0; errors = 0; stall_prev = 1'b0; prev_res = '0; prev_flags = '0;
    got_res = '0; got_flags = '0;
    bus.in_valid = 1'b0; bus.dato_a = '0; bus.dato_b = '0; bus.op = '0; bus.out_ready = 1'b1;

    vecs[0]  = '{8'h20, 8'h7F, 8'h01, 8'h80, 5'b01010};
    vecs[1]  = '{8'h22, 8'h05, 8'h05, 8'h00, 5'b00001};
    vecs[2]  = '{8'h22, 8'h00, 8'h01, 8'hFF, 5'b00110};
    vecs[3]  = '{8'h03, 8'h80, 8'h03, 8'hF0, 5'b00010};
    vecs[4]  = '{8'h03, 8'h80, 8'h09, 8'hFF, 5'b00010};
    vecs[5]  = '{8'h02, 8'h80, 8'h08, 8'h00, 5'b00001};
    vecs[6]  = '{8'h3F, 8'h12, 8'h34, 8'hAA, 5'b10010};
    vecs[7]  = '{8'h20, 8'hFF, 8'h01, 8'h00, 5'b00101};
    vecs[8]  = '{8'h24, 8'hF0, 8'h3C, 8'h30, 5'b00000};
    vecs[9]  = '{8'h25, 8'h0F, 8'hF0, 8'hFF, 5'b00010};
    vecs[10] = '{8'h26, 8'hAA, 8'hAA, 8'h00, 5'b00001};
    vecs[11] = '{8'h27, 8'h00, 8'h00, 8'hFF, 5'b00010};
    vecs[12] = '{8'h02, 8'h80, 8'h01, 8'h40, 5'b00000};
    vecs[13] = '{8'h22, 8'h80, 8'h01, 8'h7F, 5'b01000};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h00};

    // power-on reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed vectors, one at a time, with latency check
    foreach (vecs[i]) begin
      fi = 1'b0;
      for (int t = 0; t < 10 && !fi; t++) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, fi, fo);
      check("vec_accept", 32'(fi), 32'd1);
      lat = 0; got = 1'b0;
      for (int t = 0; t < 6 && !got; t++) begin
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, fi, fo);
        lat++;
        if (fo) got = 1'b1;
      end
      check("vec_output_seen", 32'(got), 32'd1);
      check("vec_latency", 32'(lat), 32'd2);
      check("vec_res", 32'(got_res), 32'(vecs[i].res));
      check("vec_flags", 32'(got_flags), 32'(vecs[i].flags));
    end

    // six back-to-back ops with the consumer stalled in cycles 3..6
    k = 0; outs = 0; saw_drop = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (k < 6) step(1'b1, 8'(8'h10 * k + 3), 8'(k + 1), ops[k], !(c >= 3 && c <= 6), fi, fo);
      else       step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, fi, fo);
      if (!bus.in_ready) saw_drop = 1'b1;
      if (fi) k++;
      if (fo) outs++;
    end
    check("stall_all_accepted", 32'(k), 32'd6);
    check("stall_all_emitted", 32'(outs), 32'd6);
    check("stall_in_ready_dropped", 32'(saw_drop), 32'd1);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset with two operations in flight
    step(1'b1, 8'h11, 8'h22, 8'h20, 1'b1, fi, fo);
    step(1'b1, 8'h33, 8'h44, 8'h26, 1'b1, fi, fo);
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_res", 32'(bus.res), 32'd0);
    check("mid_rst_flags", 32'(bus.flags), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, fi, fo);
    step(1'b1, 8'h01, 8'h02, 8'h20, 1'b1, fi, fo);
    step(1'b1, 8'hF0, 8'h04, 8'h03, 1'b1, fi, fo);
    drain("post_rst_drain");

    // random traffic with random back-pressure
    for (int t = 0; t < 600; t++) begin
      o = ops[$urandom_range(0, 8)];
      if (o == 8'h00) o = 8'($urandom());
      a = 8'($urandom());
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom());
      step(1'($urandom_range(0, 3) != 0), a, b, o, 1'($urandom_range(0, 3) != 0), fi, fo);
    end
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
